serial_paralelo_rx: RTL and testbench

Single-lane serial-to-parallel receiver for the PHY receive path, directly downstream of one serial output lane of `phy_tx`. It takes a 1-bit MSB-first stream at `clk_32f`, hunts for the comma/idle character, requires a run of consecutive commas to declare byte lock, then emits 8-bit data bytes with a valid flag. In `phy_rx`, two instances, one per lane, feed the byte-unstriping and 8→32 width-conversion stages.

---
 rtl/phy_pkg.sv | 26 ++
 rtl/rx_sync_fsm.sv | 115 +++++++++++
 rtl/serial_paralelo_rx.sv | 69 ++++++
 tb/tb_serial_paralelo_rx.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared PHY receive constants, sync FSM state encoding and the deserialized byte payload.
package phy_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned CNT_W          = 3;
    localparam int unsigned SYNC_COUNT_DEF = 4;

    localparam logic [BYTE_W-1:0] COMMA_K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_ALIGN  = 2'b01,
        ST_ACTIVE = 2'b10
    } rx_state_t;

    typedef struct packed {
        logic              valid;
        logic [BYTE_W-1:0] data;
    } rx_byte_t;

    // Modulo-8 step shared by the bit and comma counters.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rx_sync_fsm.sv
// Byte-lock tracker: hunts for a comma at any offset, then counts aligned commas
// until SYNC_COUNT is reached; owns the bit counter, comma counter and lock flag.
module rx_sync_fsm
    import phy_pkg::*;
#(
    parameter int unsigned SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             i_is_comma,
    input  logic             i_boundary,
    output logic [CNT_W-1:0] o_bit_cnt,
    output rx_state_t        o_state,
    output logic             o_active
);

    localparam logic [CNT_W-1:0] SYNC_TGT    = CNT_W'(SYNC_COUNT);
    localparam logic             DIRECT_LOCK = (SYNC_COUNT == 1);

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_bc_cnt;
    logic             r_active;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [CNT_W-1:0] w_bc_cnt_nxt;
    logic             w_active_nxt;
    logic [CNT_W-1:0] w_bc_inc;

    assign w_bc_inc = cnt_inc(r_bc_cnt);

    // State and counter registers; reset wins over every other update.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state   <= ST_HUNT;
            r_bit_cnt <= '0;
            r_bc_cnt  <= '0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bc_cnt  <= w_bc_cnt_nxt;
            r_active  <= w_active_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HUNT: begin
                if (i_is_comma) begin
                    w_state_nxt = DIRECT_LOCK ? ST_ACTIVE : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (i_boundary) begin
                    if (!i_is_comma) begin
                        w_state_nxt = ST_HUNT;
                    end else if (w_bc_inc == SYNC_TGT) begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                w_state_nxt = ST_ACTIVE;
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    // Counter and lock-flag updates.
    always_comb begin
        w_bit_cnt_nxt = r_bit_cnt;
        w_bc_cnt_nxt  = r_bc_cnt;
        w_active_nxt  = r_active;
        case (r_state)
            ST_HUNT: begin
                if (i_is_comma) begin
                    w_bit_cnt_nxt = '0;
                    w_bc_cnt_nxt  = CNT_W'(1);
                    w_active_nxt  = DIRECT_LOCK;
                end
            end
            ST_ALIGN: begin
                w_bit_cnt_nxt = cnt_inc(r_bit_cnt);
                if (i_boundary) begin
                    if (i_is_comma) begin
                        w_bc_cnt_nxt = w_bc_inc;
                        if (w_bc_inc == SYNC_TGT) begin
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        w_bc_cnt_nxt = '0;
                    end
                end
            end
            ST_ACTIVE: begin
                w_bit_cnt_nxt = cnt_inc(r_bit_cnt);
            end
            default: begin
                w_bit_cnt_nxt = '0;
                w_bc_cnt_nxt  = '0;
                w_active_nxt  = 1'b0;
            end
        endcase
    end

    assign o_bit_cnt = r_bit_cnt;
    assign o_state   = r_state;
    assign o_active  = r_active;

endmodule

// File: rtl/serial_paralelo_rx.sv
// Single-lane MSB-first deserializer: aligns on the comma character and emits
// registered data bytes with a valid flag once byte lock is achieved.
module serial_paralelo_rx
    import phy_pkg::*;
#(
    parameter int unsigned      WIDTH      = BYTE_W,
    parameter logic [WIDTH-1:0] COMMA      = COMMA_K28_5,
    parameter int unsigned      SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    // Only the 7 newest bits are kept: the oldest bit of a full shift register
    // falls out of the assembled byte and would never be read.
    logic [WIDTH-2:0] r_shreg;
    logic [WIDTH-1:0] w_byte;
    logic             w_is_comma;
    logic             w_boundary;
    logic             w_load;
    logic [CNT_W-1:0] w_bit_cnt;
    rx_state_t        w_state;
    logic             w_active;
    rx_byte_t         r_out;

    assign w_byte     = {r_shreg, data_in};
    assign w_is_comma = (w_byte == COMMA);
    assign w_boundary = (w_bit_cnt == CNT_W'(7));
    assign w_load     = (w_state == ST_ACTIVE) && w_boundary;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_shreg <= '0;
        end else begin
            r_shreg <= w_byte[WIDTH-2:0];
        end
    end

    rx_sync_fsm #(
        .SYNC_COUNT (SYNC_COUNT)
    ) u_sync_fsm (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .i_is_comma (w_is_comma),
        .i_boundary (w_boundary),
        .o_bit_cnt  (w_bit_cnt),
        .o_state    (w_state),
        .o_active   (w_active)
    );

    // Output byte is refreshed only at locked byte boundaries; a comma clears it.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_out <= '0;
        end else if (w_load) begin
            r_out.valid <= !w_is_comma;
            r_out.data  <= w_is_comma ? '0 : w_byte;
        end
    end

    assign data_out  = r_out.data;
    assign valid_out = r_out.valid;
    assign active    = w_active;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed and random bit streams compared edge by
// edge against a stream-search reference model.
module tb_serial_paralelo_rx;

    localparam int         MAXN  = 512;
    localparam int         SYNC  = 4;
    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    serial_paralelo_rx #(
        .WIDTH      (8),
        .COMMA      (COMMA),
        .SYNC_COUNT (SYNC)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_32f = ~clk_32f;

    int n_total = 0;
    int n_bad   = 0;

    bit         stim  [MAXN];
    int         n_stim;
    logic [7:0] obs_d [MAXN];
    logic       obs_v [MAXN];
    logic       obs_a [MAXN];
    logic [7:0] exp_d [MAXN];
    logic       exp_v [MAXN];
    logic       exp_a [MAXN];

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            stim[n_stim] = b[k];
            n_stim++;
        end
    endtask

    task automatic push_rand_bits(input int n);
        for (int k = 0; k < n; k++) begin
            stim[n_stim] = 1'($urandom);
            n_stim++;
        end
    endtask

    // Byte formed by stream positions e-7..e (positions before the stream start read as 0).
    function automatic logic [7:0] byte_at(input int e);
        logic [7:0] v = '0;
        for (int k = e - 7; k <= e; k++) v = {v[6:0], (k >= 0) ? stim[k] : 1'b0};
        return v;
    endfunction

    // Reference: find the first comma followed by SYNC-1 further commas every 8 bits;
    // after lock, every 8th position updates the output byte.
    task automatic model_stream();
        int         e         = 0;
        int         lock_edge = -1;
        logic [7:0] cur_d     = '0;
        logic       cur_v     = 1'b0;
        while (e < n_stim && lock_edge < 0) begin
            if (byte_at(e) == COMMA) begin
                int k = 1;
                while (k < SYNC && e + 8 * k < n_stim && byte_at(e + 8 * k) == COMMA) k++;
                if (k == SYNC) lock_edge = e + 8 * (SYNC - 1);
                else if (e + 8 * k >= n_stim) e = n_stim;
                else e = e + 8 * k + 1;
            end else begin
                e++;
            end
        end
        for (int i = 0; i < n_stim; i++) begin
            if (lock_edge >= 0 && i > lock_edge && (i - lock_edge) % 8 == 0) begin
                cur_v = (byte_at(i) != COMMA);
                cur_d = cur_v ? byte_at(i) : 8'h00;
            end
            exp_d[i] = cur_d;
            exp_v[i] = cur_v;
            exp_a[i] = (lock_edge >= 0 && i >= lock_edge);
        end
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        data_in = 1'($urandom);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
    endtask

    // Drives stim[0..n_stim-1], one bit per edge, recording outputs 1 time unit after each edge.
    task automatic run_stream(input bit do_reset);
        if (do_reset) apply_reset();
        for (int i = 0; i < n_stim; i++) begin
            data_in = stim[i];
            @(posedge clk_32f);
            #1;
            obs_d[i] = data_out;
            obs_v[i] = valid_out;
            obs_a[i] = active;
        end
        model_stream();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        data_in = 1'b1;
        repeat (2) @(posedge clk_32f);
        #1;
        reset = 1'b0;
        n_total++;
        if (data_out !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data got=%h want=00", data_out);
        end
        n_total++;
        if (valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid got=%b want=0", valid_out);
        end
        n_total++;
        if (active !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_active got=%b want=0", active);
        end
    endtask

    task automatic test_basic_lock();
        logic [7:0] want [4] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
        n_stim = 0;
        repeat (4) push_byte(COMMA);
        for (int j = 0; j < 4; j++) push_byte(want[j]);
        run_stream(1'b1);
        for (int i = 0; i < n_stim; i++) begin
            n_total++;
            if (obs_d[i] !== exp_d[i] || obs_v[i] !== exp_v[i] || obs_a[i] !== exp_a[i]) begin
                n_bad++;
                $display("FAIL basic_trace edge=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                         i + 1, obs_d[i], obs_v[i], obs_a[i], exp_d[i], exp_v[i], exp_a[i]);
            end
        end
        n_total++;
        if (obs_a[30] !== 1'b0 || obs_a[31] !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_lock_edge got a31=%b a32=%b want 0 1", obs_a[30], obs_a[31]);
        end
        n_total++;
        if (obs_v[38] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_valid_before got=%b want=0", obs_v[38]);
        end
        for (int j = 0; j < 4; j++) begin
            n_total++;
            if (obs_d[39 + 8 * j] !== want[j] || obs_v[39 + 8 * j] !== 1'b1) begin
                n_bad++;
                $display("FAIL basic_byte%0d got d=%h v=%b want d=%h v=1",
                         j, obs_d[39 + 8 * j], obs_v[39 + 8 * j], want[j]);
            end
        end
    endtask

    task automatic test_unaligned();
        n_stim = 0;
        push_rand_bits(3);
        repeat (5) push_byte(COMMA);
        push_byte(8'h03);
        run_stream(1'b1);
        for (int i = 0; i < n_stim; i++) begin
            n_total++;
            if (obs_d[i] !== exp_d[i] || obs_v[i] !== exp_v[i] || obs_a[i] !== exp_a[i]) begin
                n_bad++;
                $display("FAIL unaligned_trace edge=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                         i + 1, obs_d[i], obs_v[i], obs_a[i], exp_d[i], exp_v[i], exp_a[i]);
            end
        end
        n_total++;
        if (obs_a[33] !== 1'b0 || obs_a[34] !== 1'b1) begin
            n_bad++;
            $display("FAIL unaligned_lock got a34=%b a35=%b want 0 1", obs_a[33], obs_a[34]);
        end
        n_total++;
        if (obs_v[42] !== 1'b0 || obs_d[50] !== 8'h03 || obs_v[50] !== 1'b1) begin
            n_bad++;
            $display("FAIL unaligned_data got v43=%b d51=%h v51=%b want 0 03 1",
                     obs_v[42], obs_d[50], obs_v[50]);
        end
    endtask

    task automatic test_align_fail();
        bit saw12 = 1'b0;
        n_stim = 0;
        push_byte(COMMA);
        push_byte(COMMA);
        push_byte(8'h12);
        repeat (4) push_byte(COMMA);
        push_byte(8'h04);
        run_stream(1'b1);
        for (int i = 0; i < n_stim; i++) begin
            n_total++;
            if (obs_d[i] !== exp_d[i] || obs_v[i] !== exp_v[i] || obs_a[i] !== exp_a[i]) begin
                n_bad++;
                $display("FAIL alignfail_trace edge=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                         i + 1, obs_d[i], obs_v[i], obs_a[i], exp_d[i], exp_v[i], exp_a[i]);
            end
            if (obs_d[i] === 8'h12) saw12 = 1'b1;
        end
        n_total++;
        if (saw12 !== 1'b0) begin
            n_bad++;
            $display("FAIL alignfail_no12 got=%b want=0", saw12);
        end
        n_total++;
        if (obs_a[54] !== 1'b0 || obs_a[55] !== 1'b1 || obs_d[63] !== 8'h04 || obs_v[63] !== 1'b1) begin
            n_bad++;
            $display("FAIL alignfail_relock got a55=%b a56=%b d64=%h v64=%b want 0 1 04 1",
                     obs_a[54], obs_a[55], obs_d[63], obs_v[63]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wd [3] = '{8'hAA, 8'h00, 8'h99};
        logic       wv [3] = '{1'b1, 1'b0, 1'b1};
        n_stim = 0;
        repeat (4) push_byte(COMMA);
        push_byte(8'hAA);
        push_byte(COMMA);
        push_byte(8'h99);
        push_byte(COMMA);
        run_stream(1'b1);
        for (int i = 0; i < n_stim; i++) begin
            n_total++;
            if (obs_d[i] !== exp_d[i] || obs_v[i] !== exp_v[i] || obs_a[i] !== exp_a[i]) begin
                n_bad++;
                $display("FAIL b2b_trace edge=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                         i + 1, obs_d[i], obs_v[i], obs_a[i], exp_d[i], exp_v[i], exp_a[i]);
            end
        end
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 8; c++) begin
                int idx = 39 + 8 * w + c;
                n_total++;
                if (obs_d[idx] !== wd[w] || obs_v[idx] !== wv[w]) begin
                    n_bad++;
                    $display("FAIL b2b_window%0d edge=%0d got d=%h v=%b want d=%h v=%b",
                             w, idx + 1, obs_d[idx], obs_v[idx], wd[w], wv[w]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_byte();
        n_stim = 0;
        repeat (4) push_byte(COMMA);
        push_byte(8'hAA);
        push_rand_bits(3);
        run_stream(1'b1);
        n_total++;
        if (obs_d[39] !== 8'hAA || obs_v[39] !== 1'b1 || obs_a[42] !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_prelock got d=%h v=%b a=%b want AA 1 1",
                     obs_d[39], obs_v[39], obs_a[42]);
        end
        reset   = 1'b1;
        data_in = 1'b1;
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        n_total++;
        if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_clear got d=%h v=%b a=%b want 00 0 0", data_out, valid_out, active);
        end
        // Three commas are not enough after reset; a fresh run of four is.
        n_stim = 0;
        repeat (3) push_byte(COMMA);
        push_byte(8'h55);
        repeat (4) push_byte(COMMA);
        push_byte(8'h77);
        run_stream(1'b0);
        for (int i = 0; i < n_stim; i++) begin
            n_total++;
            if (obs_d[i] !== exp_d[i] || obs_v[i] !== exp_v[i] || obs_a[i] !== exp_a[i]) begin
                n_bad++;
                $display("FAIL midrst_trace edge=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                         i + 1, obs_d[i], obs_v[i], obs_a[i], exp_d[i], exp_v[i], exp_a[i]);
            end
        end
        n_total++;
        if (obs_a[62] !== 1'b0 || obs_a[63] !== 1'b1 || obs_d[71] !== 8'h77) begin
            n_bad++;
            $display("FAIL midrst_relock got a63=%b a64=%b d72=%h want 0 1 77",
                     obs_a[62], obs_a[63], obs_d[71]);
        end
    endtask

    // 0x5A never holds four consecutive ones, so no rotation of it is a comma
    // (0x5E would be: it is the comma shifted by one bit).
    task automatic test_no_comma();
        bit any_hi = 1'b0;
        n_stim = 0;
        repeat (25) push_byte(8'h5A);
        run_stream(1'b1);
        for (int i = 0; i < n_stim; i++) begin
            if (obs_a[i] !== 1'b0 || obs_v[i] !== 1'b0 || obs_d[i] !== 8'h00) any_hi = 1'b1;
            n_total++;
            if (obs_d[i] !== exp_d[i] || obs_v[i] !== exp_v[i] || obs_a[i] !== exp_a[i]) begin
                n_bad++;
                $display("FAIL nocomma_trace edge=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                         i + 1, obs_d[i], obs_v[i], obs_a[i], exp_d[i], exp_v[i], exp_a[i]);
            end
        end
        n_total++;
        if (any_hi !== 1'b0) begin
            n_bad++;
            $display("FAIL nocomma_quiet got=%b want=0", any_hi);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int nb;
            n_stim = 0;
            push_rand_bits($urandom_range(0, 12));
            repeat ($urandom_range(2, 6)) push_byte(COMMA);
            nb = $urandom_range(6, 10);
            for (int j = 0; j < nb; j++) begin
                if ($urandom_range(0, 3) == 0) push_byte(COMMA);
                else push_byte(8'($urandom));
            end
            run_stream(1'b1);
            for (int i = 0; i < n_stim; i++) begin
                n_total++;
                if (obs_d[i] !== exp_d[i] || obs_v[i] !== exp_v[i] || obs_a[i] !== exp_a[i]) begin
                    n_bad++;
                    $display("FAIL random%0d_trace edge=%0d got d=%h v=%b a=%b want d=%h v=%b a=%b",
                             it, i + 1, obs_d[i], obs_v[i], obs_a[i], exp_d[i], exp_v[i], exp_a[i]);
                end
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 1'b0;
        n_stim  = 0;
        test_reset();
        test_basic_lock();
        test_unaligned();
        test_align_fail();
        test_back_to_back();
        test_reset_mid_byte();
        test_no_comma();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
